// File: rtl/button_pulse_gen_pkg.sv
// rtl/button_pulse_gen_pkg.sv - shared state encodings and default timing for the button conditioner
package button_pulse_gen_pkg;

  // 2'd3 is unused; the FSM recovers from it to S_IDLE
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Defaults for the 5 MHz divided clock
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_HOLD_CYCLES     = 2500000;
  localparam int DEF_REPEAT_CYCLES   = 1000000;
  localparam int DEF_REPEAT_EN       = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - N-stage flop synchronizer with synchronous reset
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - synchronize, debounce and pulse a pushbutton, with optional auto-repeat
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_active
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYCLES - 1);
  localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REPEAT_CYCLES - 1);

  logic            btn_s;
  logic [DB_W-1:0] db_cnt;
  logic            differs;
  logic            db_done;
  logic            rise;
  logic            fall;

  state_t          state_q, state_d;
  logic [TM_W-1:0] timer_q, timer_d;
  logic            press_d;
  logic            release_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_in),
    .q     (btn_s)
  );

  assign differs = (btn_s != button_level);
  assign db_done = differs && (db_cnt == DB_LAST);
  assign rise    = db_done && btn_s;
  assign fall    = db_done && !btn_s;

  // Any sample matching the current level restarts the stability count
  always_ff @(posedge clk) begin
    if (reset) begin
      button_level <= 1'b0;
      db_cnt       <= '0;
    end else if (!differs) begin
      db_cnt <= '0;
    end else if (db_done) begin
      button_level <= btn_s;
      db_cnt       <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          timer_d = '0;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else if (REPEAT_EN != 0) begin
          if (timer_q == HOLD_LAST) begin
            press_d = 1'b1;
            timer_d = '0;
            state_d = S_REPEAT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        // Release takes priority over a coinciding repeat expiry
        if (fall) begin
          release_d = 1'b1;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else if (timer_q == REP_LAST) begin
          press_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_active <= (state_d == S_REPEAT);
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb/tb_button_pulse_gen.sv - self-checking bench for button_pulse_gen
module tb_button_pulse_gen;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic reset;
  logic button_in;
  logic l0, p0, r0, a0;
  logic l1, p1, r1, a1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_pulse_gen #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) dut_rep (
    .clk(clk), .reset(reset), .button_in(button_in),
    .button_level(l0), .press_pulse(p0), .release_pulse(r0), .repeat_active(a0)
  );

  button_pulse_gen #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .reset(reset), .button_in(button_in),
    .button_level(l1), .press_pulse(p1), .release_pulse(r1), .repeat_active(a1)
  );

  // Model: level flips once the DEB samples that have cleared the synchronizer
  // all disagree with it; pulses follow from elapsed edges since the press.
  logic hist[$];
  logic m_level;
  int   m_d;
  logic active = 1'b0;
  logic all_diff, rose, fell;
  logic exp_press[2], exp_rel[2], exp_rep[2];

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < SYNC + DEB; i++) hist.push_back(1'b0);
      m_level = 1'b0;
      m_d     = 0;
      for (int k = 0; k < 2; k++) begin
        exp_press[k] = 1'b0; exp_rel[k] = 1'b0; exp_rep[k] = 1'b0;
      end
      active = 1'b1;
    end else if (active) begin
      hist.push_back(button_in);
      void'(hist.pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[i] == m_level) all_diff = 1'b0;
      rose = all_diff && !m_level;
      fell = all_diff && m_level;
      if (all_diff) m_level = !m_level;
      if (rose) m_d = 0;
      else if (m_level) m_d++;
      for (int k = 0; k < 2; k++) begin
        exp_press[k] = rose; exp_rel[k] = fell; exp_rep[k] = 1'b0;
      end
      if (m_level && !rose && m_d >= HOLD) begin
        exp_press[0] = ((m_d - HOLD) % REP) == 0;
        exp_rep[0]   = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      cmp("level0", l0, m_level);
      cmp("press0", p0, exp_press[0]);
      cmp("release0", r0, exp_rel[0]);
      cmp("repeat0", a0, exp_rep[0]);
      cmp("level1", l1, m_level);
      cmp("press1", p1, exp_press[1]);
      cmp("release1", r1, exp_rel[1]);
      cmp("repeat1", a1, exp_rep[1]);
    end
  end

  // Per-edge records of each scenario, bit i = value just after edge i
  logic [63:0] press_v, rel_v, lvl_v, rep_v, press2_v, rep2_v;

  function automatic logic [63:0] ones(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b(input int n);
    return 64'd1 << n;
  endfunction

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run(input logic [63:0] pat, input int n, input int rst_at);
    press_v = '0; rel_v = '0; lvl_v = '0; rep_v = '0; press2_v = '0; rep2_v = '0;
    for (int i = 0; i < n; i++) begin
      button_in = pat[i];
      reset     = (i == rst_at);
      @(posedge clk);
      #1;
      press_v[i] = p0; rel_v[i] = r0; lvl_v[i] = l0; rep_v[i] = a0;
      press2_v[i] = p1; rep2_v[i] = a1;
    end
    reset     = 1'b0;
    button_in = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    button_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk64("reset_state", {60'd0, l0, p0, r0, a0}, 64'd0);
    chk64("reset_state_norep", {60'd0, l1, p1, r1, a1}, 64'd0);

    // Clean press, 8 cycles
    run(ones(0, 7), 20, -1);
    chk64("clean_press", press_v, b(5));
    chk64("clean_release", rel_v, b(13));
    chk64("clean_level", lvl_v, ones(5, 12));

    // Bounce 1,0,1,0 then steady high
    run(b(0) | b(2) | ones(4, 11), 25, -1);
    chk64("bounce_press", press_v, b(9));
    chk64("bounce_release", rel_v, b(17));

    // Long hold with auto-repeat; non-repeating instance sees one press
    run(ones(0, 39), 51, -1);
    chk64("repeat_press", press_v, b(5) | b(15) | b(20) | b(25) | b(30) | b(35) | b(40));
    chk64("repeat_active", rep_v, ones(15, 44));
    chk64("repeat_release", rel_v, b(45));
    chk64("norep_press", press2_v, b(5));
    chk64("norep_active", rep2_v, 64'd0);

    // Debounced fall lands on the edge of a scheduled repeat pulse
    run(ones(0, 19), 31, -1);
    chk64("collide_press", press_v, b(5) | b(15) | b(20));
    chk64("collide_release", rel_v, b(25));
    chk64("collide_active", rep_v, ones(15, 24));

    // Reset while repeating with the button held
    run(ones(0, 29), 41, 18);
    chk64("rst_press", press_v, b(5) | b(15) | b(24) | b(34));
    chk64("rst_release", rel_v, b(35));
    chk64("rst_level", lvl_v, ones(5, 17) | ones(24, 34));
    chk64("rst_active", rep_v, ones(15, 17) | b(34));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
